// File: rtl/cmp_irq_ctrl_pkg.sv
// Shared types and constants for the compare/interrupt controller.
package cmp_irq_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StGrant   = 2'd1,
      StCompare = 2'd2,
      StIrq     = 2'd3
   } state_e;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   function automatic logic [1:0] idx_to_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/cmp_irq_ctrl_rr_arb2.sv
// Two-input round-robin arbiter; last holds the index granted on the most recent advance.
module rr_arb2
   import cmp_irq_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant,
   output logic       last
);

   logic last_q;

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // Contention goes to whoever did not win last time
         2'b11:   grant = (last_q == REQ1) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= REQ1;
      end else if (advance && (|grant)) begin
         last_q <= grant[1];
      end
   end

   assign last = last_q;

endmodule

// File: rtl/cmp_irq_ctrl.sv
// Arbitrated operand comparator raising a level interrupt on mismatch.
// Optional saturating mismatch counter enabled by CMP_IRQ_MISMATCH_CNT_EN.
module cmp_irq_ctrl
   import cmp_irq_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req,
   input  logic [DATA_W-1:0] data_a0,
   input  logic [DATA_W-1:0] data_b0,
   input  logic [DATA_W-1:0] data_a1,
   input  logic [DATA_W-1:0] data_b1,
   output logic [1:0]        gnt,
   output logic              read_strobe,
   output logic              interrupt,
   output logic              irq_src,
   input  logic              irq_ack,
   output logic              busy,
   output logic [CNT_W-1:0]  mismatch_cnt
);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] op_a_q, op_b_q;
   logic              irq_src_q;
   logic [1:0]        arb_grant;
   logic              sel;
   logic              advance;
   logic              mismatch;

   assign advance  = (state_q == StIdle) && (|req);
   assign mismatch = |(op_a_q ^ op_b_q);

   // The arbiter's last pointer doubles as the selected requester for the whole transaction
   rr_arb2 u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .advance (advance),
      .grant   (arb_grant),
      .last    (sel)
   );

   always_comb begin
      state_d     = state_q;
      gnt         = 2'b00;
      read_strobe = 1'b0;
      interrupt   = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         StIdle: begin
            busy = 1'b0;
            if (|req) state_d = StGrant;
         end
         StGrant: begin
            gnt     = idx_to_onehot(sel);
            state_d = StCompare;
         end
         StCompare: begin
            read_strobe = 1'b1;
            state_d     = mismatch ? StIrq : StIdle;
         end
         StIrq: begin
            interrupt = 1'b1;
            if (irq_ack) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         op_a_q    <= '0;
         op_b_q    <= '0;
         irq_src_q <= REQ0;
      end else begin
         state_q <= state_d;
         if (state_q == StGrant) begin
            op_a_q <= (sel == REQ1) ? data_a1 : data_a0;
            op_b_q <= (sel == REQ1) ? data_b1 : data_b0;
         end
         if ((state_q == StCompare) && mismatch) begin
            irq_src_q <= sel;
         end
      end
   end

   assign irq_src = irq_src_q;

`ifdef CMP_IRQ_MISMATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if ((state_q == StCompare) && mismatch && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign mismatch_cnt = cnt_q;
`else
   assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_cmp_irq_ctrl.sv
// Bench for cmp_irq_ctrl: directed scenarios plus random transactions against a reference model.
module tb_cmp_irq_ctrl;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 2;
`ifdef CMP_IRQ_MISMATCH_CNT_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        req;
   logic [DATA_W-1:0] data_a0, data_b0, data_a1, data_b1;
   logic [1:0]        gnt;
   logic              read_strobe;
   logic              interrupt;
   logic              irq_src;
   logic              irq_ack;
   logic              busy;
   logic [CNT_W-1:0]  mismatch_cnt;

   int tests = 0;
   int fails = 0;

   // Reference model state: who won last, which source is reported, expected count
   int last_m;
   int src_m;
   int cnt_m;

   cmp_irq_ctrl #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .data_a0      (data_a0),
      .data_b0      (data_b0),
      .data_a1      (data_a1),
      .data_b1      (data_b1),
      .gnt          (gnt),
      .read_strobe  (read_strobe),
      .interrupt    (interrupt),
      .irq_src      (irq_src),
      .irq_ack      (irq_ack),
      .busy         (busy),
      .mismatch_cnt (mismatch_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      last_m = 1;
      src_m  = 0;
      cnt_m  = 0;
   endtask

   // One request/compare transaction starting in an IDLE cycle; ack_wait < 0 leaves the irq pending
   task automatic txn(input logic [1:0] r, input bit hold, input int ack_wait);
      int w;
      bit mm;
      req = r;
      @(posedge clk); #1;
      if (r == 2'b11) w = 1 - last_m;
      else            w = (r == 2'b10) ? 1 : 0;
      last_m = w;
      check("gnt", gnt, (w == 1) ? 2 : 1);
      check("busy_grant", busy, 1);
      if (!hold) req = 2'b00;
      @(posedge clk); #1;
      check("read_strobe", read_strobe, 1);
      check("gnt_pulse", gnt, 0);
      mm = (w == 1) ? (data_a1 != data_b1) : (data_a0 != data_b0);
      if (mm) begin
         src_m = w;
         if (CntEn && cnt_m < (1 << CNT_W) - 1) cnt_m++;
      end
      @(posedge clk); #1;
      check("interrupt", interrupt, mm);
      check("irq_src", irq_src, src_m);
      check("busy_post", busy, mm);
      check("mismatch_cnt", mismatch_cnt, cnt_m);
      if (mm && ack_wait >= 0) begin
         for (int i = 0; i < ack_wait; i++) begin
            @(posedge clk); #1;
            check("irq_held", interrupt, 1);
         end
         irq_ack = 1'b1;
         @(posedge clk); #1;
         irq_ack = 1'b0;
         check("irq_cleared", interrupt, 0);
         check("busy_cleared", busy, 0);
      end
   endtask

   initial begin
      reset   = 1'b1;
      req     = 2'b00;
      irq_ack = 1'b0;
      data_a0 = '0; data_b0 = '0; data_a1 = '0; data_b1 = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_strobe", read_strobe, 0);
      check("rst_irq", interrupt, 0);
      check("rst_src", irq_src, 0);
      check("rst_busy", busy, 0);
      check("rst_cnt", mismatch_cnt, 0);
      reset = 1'b0;
      model_reset();

      // Contention with both requests held and matching data: 01, 10, 01, 10
      data_a0 = 8'h5A; data_b0 = 8'h5A; data_a1 = 8'hC3; data_b1 = 8'hC3;
      for (int k = 0; k < 4; k++) txn(2'b11, 1'b1, 0);
      req = 2'b00;

      // Single matching request
      data_a0 = 8'hA5; data_b0 = 8'hA5;
      txn(2'b01, 1'b0, 0);

      // Mismatch on requester 1, acked after two cycles
      data_a1 = 8'h3C; data_b1 = 8'h3D;
      txn(2'b10, 1'b0, 2);

      // Spurious ack in IDLE, then a mismatch acked in the cycle interrupt rises
      irq_ack = 1'b1;
      @(posedge clk); #1;
      irq_ack = 1'b0;
      check("spur_irq", interrupt, 0);
      check("spur_busy", busy, 0);
      data_a0 = 8'h11; data_b0 = 8'h22;
      txn(2'b01, 1'b0, 0);

      // Reset while an interrupt is pending
      data_a1 = 8'h01; data_b1 = 8'h02;
      txn(2'b10, 1'b0, -1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rstirq_irq", interrupt, 0);
      check("rstirq_busy", busy, 0);
      check("rstirq_cnt", mismatch_cnt, 0);
      check("rstirq_src", irq_src, 0);
      model_reset();
      data_a0 = 8'h77; data_b0 = 8'h77;
      txn(2'b01, 1'b0, 0);

      // Five mismatches in a row: counter saturates when enabled
      for (int k = 0; k < 5; k++) begin
         data_a0 = 8'(k);
         data_b0 = ~8'(k);
         txn(2'b01, 1'b0, k % 2);
      end

      // Random transactions
      for (int k = 0; k < 40; k++) begin
         data_a0 = 8'($urandom);
         data_b0 = ($urandom_range(0, 1) == 1) ? data_a0 : 8'($urandom);
         data_a1 = 8'($urandom);
         data_b1 = ($urandom_range(0, 1) == 1) ? data_a1 : 8'($urandom);
         txn(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end
      req = 2'b00;
      @(posedge clk); #1;
      check("final_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
